// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency-sweep controller slice:
// default widths and the sweep state encoding.
package dds_pkg;

    localparam int FTW_W_DEF   = 32;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Control/status bundle between a sweep requester and dds_sweep_ctrl.
// The phase_clr signal exists only when DDS_PHASE_CLR_EN is defined.
interface dds_sweep_ctrl_if
    import dds_pkg::*;
#(
    parameter int FTW_W   = FTW_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
);

    logic               start;
    logic               stop;
    logic               mode;
    logic [FTW_W-1:0]   ftw_start;
    logic [FTW_W-1:0]   ftw_stop;
    logic [FTW_W-1:0]   ftw_step;
    logic [DWELL_W-1:0] dwell;
    logic [FTW_W-1:0]   ftw;
    logic               ftw_valid;
    logic               busy;
    logic               done;
    logic               cfg_err;
`ifdef DDS_PHASE_CLR_EN
    logic               phase_clr;
`endif

    // Requester side: issues commands and configuration, observes the sweep.
    modport master (
        output start, stop, mode, ftw_start, ftw_stop, ftw_step, dwell,
`ifdef DDS_PHASE_CLR_EN
        input  phase_clr,
`endif
        input  ftw, ftw_valid, busy, done, cfg_err
    );

    // Controller side.
    modport slave (
        input  start, stop, mode, ftw_start, ftw_stop, ftw_step, dwell,
`ifdef DDS_PHASE_CLR_EN
        output phase_clr,
`endif
        output ftw, ftw_valid, busy, done, cfg_err
    );

endinterface

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter. A load value of zero is treated as one.
// expire is registered and is high during the last cycle of each dwell.
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk_50mhz,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] value,
    output logic               expire
);

    localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [DWELL_W-1:0] count_d, count_q;
    logic               expire_d, expire_q;

    // Next count: reload (zero promoted to one), otherwise count down to zero and park.
    always_comb begin
        count_d = count_q;
        if (load) begin
            if (value == CNT_ZERO) begin
                count_d = CNT_ONE;
            end else begin
                count_d = value;
            end
        end else if (count_q != CNT_ZERO) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
        expire_d = (count_d == CNT_ONE);
    end

    // Counter and expire flag registers.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            count_q  <= CNT_ZERO;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller feeding the FTW of a DDS core.
// Steps ftw from start to stop (saturating at stop, never wrapping), holding
// each value for max(dwell,1) cycles, single-shot or continuous.
// Optional feature macro: DDS_PHASE_CLR_EN adds phase_clr, which pulses with
// every ftw_valid that loads the first value of a pass.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FTW_W   = FTW_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic             clk_50mhz,
    input  logic             rst,
    dds_sweep_ctrl_if.slave  bus
);

    localparam logic [FTW_W-1:0]   FTW_ZERO   = {FTW_W{1'b0}};
    localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};

    sweep_state_t       state_d, state_q;
    logic [FTW_W-1:0]   ftw_d, ftw_q;
    logic [FTW_W-1:0]   cfg_start_d, cfg_start_q;
    logic [FTW_W-1:0]   cfg_stop_d, cfg_stop_q;
    logic [FTW_W-1:0]   cfg_step_d, cfg_step_q;
    logic               cfg_mode_d, cfg_mode_q;
    logic [DWELL_W-1:0] cfg_dwell_d, cfg_dwell_q;
    logic               ftw_valid_d, ftw_valid_q;
    logic               busy_d, busy_q;
    logic               done_d, done_q;
    logic               cfg_err_d, cfg_err_q;
`ifdef DDS_PHASE_CLR_EN
    logic               phase_clr_d, phase_clr_q;
`endif

    logic               timer_load_s;
    logic [DWELL_W-1:0] timer_value_s;
    logic               timer_expire_s;
    logic [FTW_W:0]     sum_s;

    dds_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .load      (timer_load_s),
        .value     (timer_value_s),
        .expire    (timer_expire_s)
    );

    // Sweep sequencing: next state, next FTW, configuration latch and output pulses.
    always_comb begin
        state_d       = state_q;
        ftw_d         = ftw_q;
        cfg_start_d   = cfg_start_q;
        cfg_stop_d    = cfg_stop_q;
        cfg_step_d    = cfg_step_q;
        cfg_mode_d    = cfg_mode_q;
        cfg_dwell_d   = cfg_dwell_q;
        ftw_valid_d   = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        cfg_err_d     = 1'b0;
        timer_load_s  = 1'b0;
        timer_value_s = cfg_dwell_q;
`ifdef DDS_PHASE_CLR_EN
        phase_clr_d   = 1'b0;
`endif
        // Carry-extended sum so an overflowing step still saturates at stop.
        sum_s = {1'b0, ftw_q} + {1'b0, cfg_step_q};

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // stop has priority over a coincident start.
                if (bus.start && !bus.stop) begin
                    if ((bus.ftw_step == FTW_ZERO) || (bus.ftw_start > bus.ftw_stop)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_start_d   = bus.ftw_start;
                        cfg_stop_d    = bus.ftw_stop;
                        cfg_step_d    = bus.ftw_step;
                        cfg_mode_d    = bus.mode;
                        cfg_dwell_d   = bus.dwell;
                        ftw_d         = bus.ftw_start;
                        ftw_valid_d   = 1'b1;
                        busy_d        = 1'b1;
                        timer_load_s  = 1'b1;
                        timer_value_s = bus.dwell;
                        state_d       = RUN;
`ifdef DDS_PHASE_CLR_EN
                        phase_clr_d   = 1'b1;
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    // Abort: freeze ftw where it is, no completion pulse.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (timer_expire_s) begin
                    if (ftw_q != cfg_stop_q) begin
                        if (sum_s >= {1'b0, cfg_stop_q}) begin
                            ftw_d = cfg_stop_q;
                        end else begin
                            ftw_d = sum_s[FTW_W-1:0];
                        end
                        ftw_valid_d  = 1'b1;
                        timer_load_s = 1'b1;
                    end else if (cfg_mode_q) begin
                        // Continuous: restart the pass with no gap cycle.
                        ftw_d        = cfg_start_q;
                        ftw_valid_d  = 1'b1;
                        timer_load_s = 1'b1;
`ifdef DDS_PHASE_CLR_EN
                        phase_clr_d  = 1'b1;
`endif
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q     <= IDLE;
            ftw_q       <= FTW_ZERO;
            cfg_start_q <= FTW_ZERO;
            cfg_stop_q  <= FTW_ZERO;
            cfg_step_q  <= FTW_ZERO;
            cfg_mode_q  <= 1'b0;
            cfg_dwell_q <= DWELL_ZERO;
            ftw_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
`ifdef DDS_PHASE_CLR_EN
            phase_clr_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ftw_q       <= ftw_d;
            cfg_start_q <= cfg_start_d;
            cfg_stop_q  <= cfg_stop_d;
            cfg_step_q  <= cfg_step_d;
            cfg_mode_q  <= cfg_mode_d;
            cfg_dwell_q <= cfg_dwell_d;
            ftw_valid_q <= ftw_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
`ifdef DDS_PHASE_CLR_EN
            phase_clr_q <= phase_clr_d;
`endif
        end
    end

    assign bus.ftw       = ftw_q;
    assign bus.ftw_valid = ftw_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;
`ifdef DDS_PHASE_CLR_EN
    assign bus.phase_clr = phase_clr_q;
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed scenarios plus randomized
// single sweeps compared against a value-list reference model.
module tb_dds_sweep_ctrl;
    import dds_pkg::*;

    logic clk_50mhz = 1'b0;
    logic rst;
    always #10 clk_50mhz = ~clk_50mhz;

    dds_sweep_ctrl_if #(.FTW_W(32), .DWELL_W(16)) bif ();

    dds_sweep_ctrl #(.FTW_W(32), .DWELL_W(16)) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .bus       (bif)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] hold_ftw;   // value ftw is expected to hold while idle
    longint ref_q[$];        // reference list of distinct FTW values in one pass

    // Reference: the ordered list of values one pass visits (saturating, no wrap).
    function automatic void build_values(longint s, longint e, longint st);
        longint v;
        ref_q.delete();
        v = s;
        while (1) begin
            ref_q.push_back(v);
            if (v == e) break;
            v = v + st;
            if (v > e) v = e;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bif.start = 1'b0; bif.stop = 1'b0; bif.mode = 1'b0;
        bif.ftw_start = 32'd0; bif.ftw_stop = 32'd0; bif.ftw_step = 32'd0; bif.dwell = 16'd0;
        repeat (3) @(posedge clk_50mhz);
        #1;
        checks++;
        if ({bif.ftw, bif.ftw_valid, bif.busy, bif.done, bif.cfg_err} !== 36'd0) begin
            errors++;
            $display("FAIL reset: got %h required 0", {bif.ftw, bif.ftw_valid, bif.busy, bif.done, bif.cfg_err});
        end
`ifdef DDS_PHASE_CLR_EN
        checks++;
        if (bif.phase_clr !== 1'b0) begin
            errors++;
            $display("FAIL reset_phase_clr: got %b required 0", bif.phase_clr);
        end
`endif
        rst = 1'b0;
        hold_ftw = 32'd0;
        @(posedge clk_50mhz); #1;
    endtask

    // One single-mode sweep; optionally pulses start once while busy.
    task automatic test_single(input string name, input logic [31:0] s, input logic [31:0] e,
                               input logic [31:0] st, input logic [15:0] dw, input bit poke);
        int d, k, total, poke_c, idx;
        logic [35:0] exp_v, got_v;
        logic exp_pc;
        build_values(longint'(s), longint'(e), longint'(st));
        d = (dw == 16'd0) ? 1 : int'(dw);
        k = ref_q.size();
        total = k * d;
        poke_c = poke ? (1 + int'($urandom % total)) : -1;
        @(negedge clk_50mhz);
        bif.mode = 1'b0; bif.ftw_start = s; bif.ftw_stop = e; bif.ftw_step = st; bif.dwell = dw;
        bif.start = 1'b1;
        @(posedge clk_50mhz); #1;
        bif.start = 1'b0;
        for (int c = 1; c <= total + 2; c++) begin
            exp_pc = 1'b0;
            if (c <= total) begin
                idx = (c - 1) / d;
                exp_pc = ((c - 1) % d == 0) && (idx == 0);
                exp_v = {ref_q[idx][31:0], ((c - 1) % d == 0), 1'b1, 1'b0, 1'b0};
            end else if (c == total + 1) begin
                exp_v = {e, 1'b0, 1'b0, 1'b1, 1'b0};
            end else begin
                exp_v = {e, 1'b0, 1'b0, 1'b0, 1'b0};
            end
            got_v = {bif.ftw, bif.ftw_valid, bif.busy, bif.done, bif.cfg_err};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s cycle %0d: got ftw/valid/busy/done/err=%h required %h", name, c, got_v, exp_v);
            end
`ifdef DDS_PHASE_CLR_EN
            checks++;
            if (bif.phase_clr !== exp_pc) begin
                errors++;
                $display("FAIL %s_phase_clr cycle %0d: got %b required %b", name, c, bif.phase_clr, exp_pc);
            end
`endif
            if (c == poke_c) begin
                bif.ftw_start = 32'd5; bif.ftw_stop = 32'd9; bif.ftw_step = 32'd1; bif.dwell = 16'd1;
                bif.start = 1'b1;
            end
            @(posedge clk_50mhz); #1;
            bif.start = 1'b0;
        end
        hold_ftw = e;
    endtask

    task automatic test_rejected(input string name, input logic [31:0] s, input logic [31:0] e,
                                 input logic [31:0] st);
        @(negedge clk_50mhz);
        bif.mode = 1'b0; bif.ftw_start = s; bif.ftw_stop = e; bif.ftw_step = st; bif.dwell = 16'd3;
        bif.start = 1'b1;
        @(posedge clk_50mhz); #1;
        bif.start = 1'b0;
        checks++;
        if ({bif.ftw, bif.ftw_valid, bif.busy, bif.done, bif.cfg_err} !== {hold_ftw, 4'b0001}) begin
            errors++;
            $display("FAIL %s pulse: got %h required %h", name,
                     {bif.ftw, bif.ftw_valid, bif.busy, bif.done, bif.cfg_err}, {hold_ftw, 4'b0001});
        end
        @(posedge clk_50mhz); #1;
        checks++;
        if ({bif.ftw, bif.ftw_valid, bif.busy, bif.done, bif.cfg_err} !== {hold_ftw, 4'b0000}) begin
            errors++;
            $display("FAIL %s after: got %h required %h", name,
                     {bif.ftw, bif.ftw_valid, bif.busy, bif.done, bif.cfg_err}, {hold_ftw, 4'b0000});
        end
    endtask

    task automatic test_continuous_abort();
        int d, k, m, idx;
        logic [35:0] exp_v, got_v;
        logic exp_pc;
        d = 2;
        build_values(64'd0, 64'd20, 64'd10);
        k = ref_q.size();
        m = k * d + d + 1;   // first cycle of the value-10 dwell in the second pass
        @(negedge clk_50mhz);
        bif.mode = 1'b1; bif.ftw_start = 32'd0; bif.ftw_stop = 32'd20; bif.ftw_step = 32'd10;
        bif.dwell = 16'd2; bif.start = 1'b1;
        @(posedge clk_50mhz); #1;
        bif.start = 1'b0;
        for (int c = 1; c <= m; c++) begin
            idx = ((c - 1) / d) % k;
            exp_pc = ((c - 1) % d == 0) && (idx == 0);
            exp_v = {ref_q[idx][31:0], ((c - 1) % d == 0), 1'b1, 1'b0, 1'b0};
            got_v = {bif.ftw, bif.ftw_valid, bif.busy, bif.done, bif.cfg_err};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL continuous cycle %0d: got %h required %h", c, got_v, exp_v);
            end
`ifdef DDS_PHASE_CLR_EN
            checks++;
            if (bif.phase_clr !== exp_pc) begin
                errors++;
                $display("FAIL continuous_phase_clr cycle %0d: got %b required %b", c, bif.phase_clr, exp_pc);
            end
`endif
            if (c == m) bif.stop = 1'b1;
            @(posedge clk_50mhz); #1;
        end
        bif.stop = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({bif.ftw, bif.ftw_valid, bif.busy, bif.done, bif.cfg_err} !== {32'd10, 4'b0000}) begin
                errors++;
                $display("FAIL abort idle %0d: got %h required %h", c,
                         {bif.ftw, bif.ftw_valid, bif.busy, bif.done, bif.cfg_err}, {32'd10, 4'b0000});
            end
            @(posedge clk_50mhz); #1;
        end
        bif.mode = 1'b0;
        hold_ftw = 32'd10;
    endtask

    task automatic test_reset_mid();
        @(negedge clk_50mhz);
        bif.mode = 1'b1; bif.ftw_start = 32'd40; bif.ftw_stop = 32'd90; bif.ftw_step = 32'd10;
        bif.dwell = 16'd3; bif.start = 1'b1;
        @(posedge clk_50mhz); #1;
        bif.start = 1'b0;
        repeat (4) @(posedge clk_50mhz);
        #1;
        checks++;
        if (bif.busy !== 1'b1 || bif.ftw !== 32'd50) begin
            errors++;
            $display("FAIL reset_mid pre: got busy=%b ftw=%0d required busy=1 ftw=50", bif.busy, bif.ftw);
        end
        rst = 1'b1;
        @(posedge clk_50mhz); #1;
        rst = 1'b0;
        checks++;
        if ({bif.ftw, bif.ftw_valid, bif.busy, bif.done, bif.cfg_err} !== 36'd0) begin
            errors++;
            $display("FAIL reset_mid: got %h required 0", {bif.ftw, bif.ftw_valid, bif.busy, bif.done, bif.cfg_err});
        end
        repeat (4) @(posedge clk_50mhz);
        #1;
        checks++;
        if ({bif.ftw, bif.ftw_valid, bif.busy} !== 34'd0) begin
            errors++;
            $display("FAIL reset_mid stays idle: got %h required 0", {bif.ftw, bif.ftw_valid, bif.busy});
        end
        bif.mode = 1'b0;
        hold_ftw = 32'd0;
    endtask

    task automatic test_random();
        logic [31:0] s, e, st;
        logic [15:0] dw;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                s  = $urandom_range(0, 2000);
                e  = s + $urandom_range(0, 1500);
                st = $urandom_range(1, 400);
            end else begin
                s  = 32'hFFFF_F000 + $urandom_range(0, 255);
                e  = 32'hFFFF_FFFF - $urandom_range(0, 255);
                st = $urandom_range(32'h100, 32'h8000_0000);
            end
            dw = 16'($urandom_range(0, 3));
            test_single($sformatf("random%0d", i), s, e, st, dw, bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_single("basic", 32'd100, 32'd130, 32'd10, 16'd4, 1'b0);
        test_single("saturation", 32'd100, 32'd125, 32'd10, 16'd1, 1'b0);
        test_single("carry", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd2, 1'b0);
        test_rejected("reject_step0", 32'd10, 32'd40, 32'd0);
        test_rejected("reject_order", 32'd50, 32'd40, 32'd5);
        test_single("start_while_busy", 32'd0, 32'd30, 32'd10, 16'd3, 1'b1);
        test_continuous_abort();
        test_reset_mid();
        test_single("dwell0", 32'd7, 32'd9, 32'd1, 16'd0, 1'b0);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep controller that sits directly upstream of the DDS core `dds_lianxi` and drives its frequency tuning word (FTW).
- Steps the FTW linearly from a start value to a stop value.
- Holds each value for a programmable number of `clk_50mhz` cycles.
- Runs single-shot or repeating.
- Lets the DDS produce chirps and stepped-frequency test signals without a processor in the loop.

## Interface
Parameters:
- `FTW_W`, 32, width of the tuning word, start/stop/step inputs and `ftw` output.
- `DWELL_W`, 16, width of the dwell-count input and internal dwell counter.

Ports:
- `clk_50mhz`  in  1  system clock, 50 MHz; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a sweep.
- `stop`  in  1  abort request, level or pulse.
- `mode`  in  1  0 = single sweep, 1 = continuous (restart at `ftw_start` after each pass).
- `ftw_start`  in  FTW_W  first tuning word; sampled on accepted `start`.
- `ftw_stop`  in  FTW_W  last tuning word; sampled on accepted `start`.
- `ftw_step`  in  FTW_W  increment per step; sampled on accepted `start`.
- `dwell`  in  DWELL_W  cycles each FTW is held; 0 is treated as 1.
- `ftw`  out  FTW_W  tuning word to the DDS.
- `ftw_valid`  out  1  one-cycle pulse when `ftw` takes a new value.
- `busy`  out  1  high while a sweep is active.
- `done`  out  1  one-cycle pulse at the end of a single-mode sweep.
- `cfg_err`  out  1  one-cycle pulse when `start` is rejected.
- `phase_clr`  out  1  present only with `DDS_PHASE_CLR_EN` (see Configuration).

## Operation
- State machine has two states: IDLE and RUN.
- **Reset:**
  - State = IDLE.
  - `ftw` = 0.
  - `ftw_valid`, `busy`, `done`, `cfg_err`, `phase_clr` = 0.
- **IDLE:**
  - `ftw` holds its last value.
  - `start` with `ftw_step == 0` or `ftw_start > ftw_stop`: pulse `cfg_err`, stay in IDLE.
  - Otherwise, on `start`:
    - latch start/stop/step/mode;
    - load `ftw <= ftw_start` and pulse `ftw_valid`;
    - load the dwell counter with D = max(`dwell`, 1);
    - go to RUN.
- **RUN:**
  - Dwell counter decrements each cycle.
  - On the last cycle of a dwell, the next value is computed as a (FTW_W+1)-bit sum S = `ftw` + step.
  - If current `ftw` != latched stop:
    - `ftw <= (S >= stop) ? stop : S[FTW_W-1:0]`;
    - pulse `ftw_valid`;
    - reload the counter.
    - Saturation covers both overshoot and carry-out; the sweep never wraps.
  - If current `ftw` == stop and mode = 1:
    - `ftw <= start`, pulse `ftw_valid`, reload the counter, stay in RUN.
  - If current `ftw` == stop and mode = 0:
    - go to IDLE, pulse `done`, drop `busy`;
    - `ftw` holds stop.
- **Input rules while running:**
  - `start` while `busy` is ignored; no `cfg_err`.
  - `stop` in RUN: next state IDLE, `ftw` holds its current value, no `done`, no `ftw_valid`.
  - `start` and `stop` in the same cycle: `stop` wins, `start` is ignored.
  - `rst` mid-sweep: all outputs return to reset values on the next edge.

## Timing
- Accepted `start` sampled at edge N. At edge N:
  - `ftw = ftw_start`, `ftw_valid = 1`, `busy = 1`.
- Each FTW is presented for exactly D cycles; `ftw_valid` is high only in the first cycle of each.
- Single pass with K distinct values lasts K·D cycles. `done` is high, with `busy` = 0, in cycle K·D after the first `ftw_valid`.
- Continuous mode: the `ftw_start` reload follows the last stop-value cycle with no gap cycle.
- `stop` asserted in cycle M: `busy` = 0 from cycle M+1.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- **`DDS_PHASE_CLR_EN` defined:**
  - Output `phase_clr` exists.
  - It pulses in the same cycle as each `ftw_valid` that loads `ftw_start` (the first value of every pass).
  - The DDS uses it to zero its phase accumulator for phase-coherent passes.
- **Not defined:**
  - Port and logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package `dds_pkg` holds:
  - `FTW_W_DEF` = 32;
  - `DWELL_W_DEF` = 16;
  - the state enum `sweep_state_t` {IDLE, RUN}.
- One sub-module, `dds_dwell_timer`:
  - loadable down-counter with `load` and value inputs;
  - `expire` output flags the last dwell cycle;
  - width DWELL_W;
  - treats 0 as 1.

## Test plan
- **Basic sweep:**
  - Stimulus: start=100, stop=130, step=10, dwell=4, mode=0.
  - Response: `ftw` 100, 110, 120, 130, each held 4 cycles; 4 `ftw_valid` pulses; `done` 16 cycles after the first pulse; `ftw` stays 130.
- **Saturation:**
  - Stimulus: start=100, stop=125, step=10, dwell=1.
  - Response: 100, 110, 120, 125, then `done`.
- **Carry-out:**
  - Stimulus: start=0xFFFF_FFF0, stop=0xFFFF_FFFF, step=0x20.
  - Response: 0xFFFF_FFF0, 0xFFFF_FFFF, `done`; no wrap to small values.
- **Rejected start:**
  - Stimulus: step=0; then start=50, stop=40.
  - Response: each gives a `cfg_err` pulse, `busy` stays 0, `ftw` unchanged.
- **Continuous mode with abort:**
  - Stimulus: mode=1, start=0, stop=20, step=10, dwell=2.
  - Response: sequence 0, 10, 20, 0, 10, …; `stop` during a value-10 dwell gives `busy`=0 next cycle, `ftw`=10, no `done`.
  - With `DDS_PHASE_CLR_EN` defined: `phase_clr` coincides with every load of 0.
- **Reset mid-sweep and start-while-busy:**
  - Stimulus: `rst` mid-sweep; `start` pulsed while busy.
  - Response: after `rst`, all outputs are 0 next cycle. `start` while busy is ignored and the sequence is unchanged.
